// File: rtl/syncnt_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
package syncnt_pkg;

    // Control FSM: IDLE until first load, RUN while timing, DONE after a one-shot expiry.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam int CNT_W_DEFAULT = 3;

endpackage

// File: rtl/syncnt_down_load_tff.sv
// T flip-flop cell with active-low asynchronous clear.
module tff (
    input  logic clk_i,
    input  logic clr_n_i,
    input  logic t_i,
    output logic q_o
);

    logic q_q;

    // Toggle on T, clear immediately when clr_n_i drops.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            q_q <= 1'b0;
        end else if (t_i) begin
            q_q <= ~q_q;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/syncnt_down_load.sv
// Loadable down-counter/timer built from tff cells with a borrow chain,
// terminal-count pulse and one-shot / auto-reload control FSM.
//
// Handshake: there is no valid/ready pair; load and en are single-cycle
// strobes sampled on every rising edge, load taking priority over en.
module syncnt_down_load
    import syncnt_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] d,
    input  logic         load,
    input  logic         en,
    input  logic         reload,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         busy
);

    cnt_state_t   state_q;
    logic [W-1:0] rl_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] t_d;
    logic [W-1:0] dec_t;
    logic         brw;
    logic         cnt_zero;
    logic         run_en;

    assign cnt_zero = (cnt_q == '0);
    assign run_en   = (state_q == RUN) && en;

    // Borrow chain: bit n toggles when every lower bit is zero.
    always_comb begin
        dec_t = '0;
        brw   = 1'b1;
        for (int n = 0; n < W; n++) begin
            dec_t[n] = brw;
            brw      = brw & ~cnt_q[n];
        end
    end

    // T-select: load beats decrement/wrap; the wrap XOR works because q is 0 there.
    always_comb begin
        t_d = '0;
        if (load) begin
            t_d = d ^ cnt_q;
        end else if (run_en) begin
            if (!cnt_zero) begin
                t_d = dec_t;
            end else if (reload) begin
                t_d = rl_q ^ cnt_q;
            end
        end
    end

    // One tff per count bit, all cleared by nrst.
    for (genvar n = 0; n < W; n++) begin : g_bit
        tff u_tff (
            .clk_i   (clk),
            .clr_n_i (nrst),
            .t_i     (t_d[n]),
            .q_o     (cnt_q[n])
        );
    end

    // Reload register captures the last loaded value; lost on reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rl_q <= '0;
        end else if (load) begin
            rl_q <= d;
        end
    end

    // Control FSM: load enters RUN from anywhere; one-shot expiry goes to DONE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else if (load) begin
            state_q <= RUN;
        end else if (run_en && cnt_zero && !reload) begin
            state_q <= DONE;
        end
    end

    assign q    = cnt_q;
    assign busy = (state_q == RUN);
    assign tc   = run_en && cnt_zero && !load;

endmodule

// File: tb/tb_syncnt_down_load.sv
// Bench for syncnt_down_load: driver pushes expected {q,tc,busy} per cycle,
// a negedge monitor pops and compares.
module tb_syncnt_down_load;

    localparam int W = 3;
    localparam int EW = W + 2;

    logic         clk;
    logic         nrst;
    logic [W-1:0] d;
    logic         load;
    logic         en;
    logic         reload;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;

    logic [EW-1:0] exp_q[$];
    int n_cmp;
    int n_bad;

    // Reference model: count value, reload value, mode (0 idle, 1 running, 2 finished).
    int m_cnt;
    int m_rl;
    int m_mode;

    syncnt_down_load #(.W(W)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .d      (d),
        .load   (load),
        .en     (en),
        .reload (reload),
        .q      (q),
        .tc     (tc),
        .busy   (busy)
    );

    // Clock and initial reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        nrst = 1'b0;
        d = '0;
        load = 1'b0;
        en = 1'b0;
        reload = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        m_cnt = 0;
        m_rl = 0;
        m_mode = 0;
    end

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({q, tc, busy} !== e) begin
                n_bad++;
                $display("FAIL cycle_out t=%0t: got q=%0d tc=%0b busy=%0b, want q=%0d tc=%0b busy=%0b",
                         $time, q, tc, busy, e[EW-1:2], e[1], e[0]);
            end
        end
    end

    // Drive one cycle of inputs, record the expected outputs, advance the model.
    task automatic drive(input logic ld, input logic [W-1:0] dv, input logic e, input logic rm);
        logic          tc_e;
        logic          busy_e;
        logic [W-1:0]  q_e;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        load = ld;
        d = dv;
        en = e;
        reload = rm;
        q_e = m_cnt[W-1:0];
        busy_e = (m_mode == 1);
        tc_e = (m_mode == 1) && e && (m_cnt == 0) && !ld;
        exp_q.push_back({q_e, tc_e, busy_e});
        if (ld) begin
            m_cnt = int'(dv);
            m_rl = int'(dv);
            m_mode = 1;
        end else if (m_mode == 1 && e) begin
            if (m_cnt > 0) m_cnt = m_cnt - 1;
            else if (rm) m_cnt = m_rl;
            else m_mode = 2;
        end
    endtask

    // Assert reset between edges and check the clear is immediate.
    task automatic async_reset();
        @(posedge clk);
        #2;
        load = 1'b0;
        en = 1'b0;
        nrst = 1'b0;
        #1;
        n_cmp++;
        if ({q, tc, busy} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got q=%0d tc=%0b busy=%0b, want q=0 tc=0 busy=0", q, tc, busy);
        end
        m_cnt = 0;
        m_rl = 0;
        m_mode = 0;
        @(posedge clk);
        @(posedge clk);
    endtask

    initial begin
        #2;
        n_cmp++;
        if ({q, tc, busy} !== '0) begin
            n_bad++;
            $display("FAIL power_on_reset: got q=%0d tc=%0b busy=%0b, want all 0", q, tc, busy);
        end

        // Reset mid-count with q=5, then enable without load.
        drive(1'b1, 3'd5, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 3'd0, 1'b0, 1'b0);
        async_reset();
        repeat (6) drive(1'b0, 3'd0, 1'b1, 1'b0);

        // One-shot countdown from 3, then rest in DONE.
        drive(1'b1, 3'd3, 1'b1, 1'b0);
        repeat (14) drive(1'b0, 3'd0, 1'b1, 1'b0);

        // Auto-reload with period 3.
        drive(1'b1, 3'd2, 1'b1, 1'b1);
        repeat (9) drive(1'b0, 3'd0, 1'b1, 1'b1);

        // Gated enable from 7.
        drive(1'b1, 3'd7, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 3'd0, (i % 2) == 0, 1'b0);

        // Load colliding with the q==0 wrap.
        drive(1'b1, 3'd1, 1'b1, 1'b1);
        drive(1'b0, 3'd0, 1'b1, 1'b1);
        drive(1'b1, 3'd5, 1'b1, 1'b1);
        repeat (8) drive(1'b0, 3'd0, 1'b1, 1'b1);

        // Edge values: zero with reload, then full range one-shot.
        drive(1'b1, 3'd0, 1'b1, 1'b1);
        repeat (5) drive(1'b0, 3'd0, 1'b1, 1'b1);
        drive(1'b1, 3'd7, 1'b1, 1'b0);
        repeat (12) drive(1'b0, 3'd0, 1'b1, 1'b0);

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            drive($urandom_range(0, 9) == 0,
                  W'($urandom_range(0, (1 << W) - 1)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1));
        end

        // Drain the scoreboard within a bounded number of cycles.
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/syncnt_down_load.md
Name: syncnt_down_load

Overview:
- Synchronous loadable down-counter/timer. It is the counting-down counterpart to the team's loadable up-counter.
- Built from the team's tff cells (T flip-flop with active-low async clear), driven by a borrow chain.
- Adds a terminal-count pulse and a one-shot / auto-reload control FSM.
- Used as a programmable delay/period generator next to the up-counters in the lab datapaths.

Parameters:
W, 3, counter width in bits (W >= 2)

Ports:
clk     input   1  clock; all state updates on rising edge
nrst    input   1  reset, asynchronous, active-low
d       input   W  load value
load    input   1  synchronous load strobe; highest priority after reset
en      input   1  count enable (decrement strobe)
reload  input   1  1 = auto-reload mode, 0 = one-shot mode; sampled every cycle
q       output  W  current count
tc      output  1  terminal-count pulse (combinational from state, q, en)
busy    output  1  high while FSM is in RUN

Behaviour:
- Clocking and reset:
  - One clock `clk`; reset is asynchronous and active-low (`nrst`).
  - `nrst`=0 forces, without waiting for a clock: q=0, internal reload register rl=0, FSM=IDLE, busy=0, tc=0.
  - Release takes effect at the next rising edge.
- Count bits:
  - Every q bit is a tff whose T input is chosen per edge.
  - load: T[n] = d[n]^q[n].
  - Reload wrap: T[n] = rl[n]^q[n].
  - Decrement: T[0] = 1, T[n] = T[n-1] & ~q[n-1] (borrow chain). Result is q-1 mod 2^W in one edge.
- FSM states:
  - IDLE: q holds; busy=0; tc=0. en is ignored.
  - RUN: busy=1.
  - DONE: q holds at 0; busy=0; tc=0. Reached only in one-shot mode.
- Priority each rising edge (after reset):
  1. load=1: q<=d, rl<=d, FSM<=RUN, from any state. Overrides en and wrap in the same cycle.
  2. RUN, en=1, q!=0: q<=q-1.
  3. RUN, en=1, q==0: tc=1 during this cycle. Then:
     - reload=1: q<=rl, stay RUN.
     - reload=0: q holds 0, FSM<=DONE.
  4. en=0: everything holds.
- tc:
  - tc = (FSM==RUN) & en & (q==0) & ~load.
  - Exactly one cycle per expiry.
  - Never asserted in IDLE or DONE.
  - Never asserted in a load cycle.
- Latency:
  - Load of value N with en held high: tc asserts in cycle N+1 after the load edge (the cycle with q==0).
  - Auto-reload period is N+1 enabled cycles.
- Boundary conditions:
  - Load d=0: next enabled RUN cycle pulses tc immediately. With reload=1, tc is continuous while en=1 (period 1).
  - Load d=2^W-1: full-range count, no overflow path.
  - Load in the same cycle as the q==0 wrap: load wins; tc=0 that cycle.
  - en deasserted mid-count: q freezes; tc cannot assert.
  - reload changed mid-count: only its value at the q==0 cycle matters.
  - nrst asserted mid-count: immediate clear to IDLE and q=0. rl is lost, so a new load is required.

Decomposition:
- Shared package `syncnt_pkg`:
  - FSM enum `cnt_state_t {IDLE, RUN, DONE}` (2-bit).
  - Constant `CNT_W_DEFAULT=3`.
- Sub-module: the existing tff cell, instantiated W times in a generate loop; nrst goes to each cell's clear.
- rl register and FSM are plain always_ff blocks with async clear on `nrst`.
- Borrow chain and T-select mux are an always_comb block in the top module; no further sub-module.

Test Plan (W=3):
1. Reset: nrst=0 mid-simulation with q=5 -> q=0, busy=0, tc=0 before the next clk edge. After release with en=1 and no load -> q stays 0, tc never asserts.
2. One-shot: load d=3, reload=0, en=1 -> q sequence 3,2,1,0. tc=1 only in the q==0 cycle. Next edge FSM=DONE, busy=0, q holds 0 for 10 further cycles.
3. Auto-reload: load d=2, reload=1, en=1 for 9 cycles -> q sequence 2,1,0,2,1,0,2,1,0. tc pulses on each q==0 cycle (3 pulses); busy stays 1.
4. Gated enable: load d=7, en toggling 1,0,1,0... -> q decrements only on en=1 edges; tc appears after exactly 8 enabled cycles. Borrow across all bits checked at 4->3.
5. Load collision: reload=1, q==0, en=1, load=1, d=5 in the same cycle -> tc=0 that cycle; next q=5; rl=5 (the following wrap reloads 5).
6. Edge values: load d=0, reload=1, en=1 -> tc high every cycle, q stays 0. Load d=7, reload=0 -> 8-cycle countdown, then DONE.
